// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern source: pattern codes, pixel type
// and frame geometry helpers.
package vga_pkg;

  localparam logic [1:0] PAT_SOLID = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_CHK   = 2'd2;
  localparam logic [1:0] PAT_ANIM  = 2'd3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic int unsigned h_total(input int unsigned bp, input int unsigned act,
                                          input int unsigned fp, input int unsigned sync);
    return bp + act + fp + sync;
  endfunction

  function automatic int unsigned v_total(input int unsigned act, input int unsigned blank);
    return act + blank;
  endfunction

endpackage

// File: rtl/vga_if.sv
// Video stream bundle: run/pattern controls in, registered sync/data stream out.
interface vga_if;
  logic        en;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;
  logic        vga_vs;
  logic        vga_hs;
  logic        vga_de;
  logic [31:0] vga_data;
  logic [7:0]  frame_cnt;
  logic        sof;

  // master is the video source
  modport master (
    input  en, mode, solid_rgb,
    output vga_vs, vga_hs, vga_de, vga_data, frame_cnt, sof
  );

  modport slave (
    output en, mode, solid_rgb,
    input  vga_vs, vga_hs, vga_de, vga_data, frame_cnt, sof
  );
endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical counters, run flag and registered vs/hs/de/sof/frame count.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACT   = 16,
  parameter int unsigned V_ACT   = 16,
  parameter int unsigned H_BP    = 4,
  parameter int unsigned H_FP    = 4,
  parameter int unsigned H_SYNC  = 4,
  parameter int unsigned V_BLANK = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  output logic       boundary_o,
  output logic       de_next_o,
  output logic [7:0] x_o,
  output logic [7:0] y_o,
  output logic       vs_o,
  output logic       hs_o,
  output logic       de_o,
  output logic       sof_o,
  output logic [7:0] frame_cnt_o
);

  localparam int unsigned HTot = h_total(H_BP, H_ACT, H_FP, H_SYNC);
  localparam int unsigned VTot = v_total(V_ACT, V_BLANK);
  localparam int unsigned HW   = $clog2(HTot);
  localparam int unsigned VW   = $clog2(VTot);

  localparam logic [HW-1:0] HActStart = HW'(H_BP);
  localparam logic [HW-1:0] HActEnd   = HW'(H_BP + H_ACT);
  localparam logic [HW-1:0] HsStart   = HW'(H_BP + H_ACT + H_FP);
  localparam logic [HW-1:0] HLast     = HW'(HTot - 1);
  localparam logic [VW-1:0] VActEnd   = VW'(V_ACT);
  localparam logic [VW-1:0] VLast     = VW'(VTot - 1);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          running_q, running_d;
  logic          vs_q, vs_d, hs_q, hs_d, de_q, de_d, sof_q, sof_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          boundary, run_eff;
  logic [HW-1:0] x_w;

  always_comb begin
    boundary  = (hcnt_q == '0) && (vcnt_q == '0);
    // en is only honoured at the frame boundary; mid-frame the latched flag rules
    run_eff   = boundary ? en_i : running_q;
    running_d = run_eff;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    if (run_eff) begin
      if (hcnt_q == HLast) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + VW'(1);
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
    end
    vs_d        = run_eff && (vcnt_q < VActEnd);
    de_d        = vs_d && (hcnt_q >= HActStart) && (hcnt_q < HActEnd);
    hs_d        = run_eff && (hcnt_q >= HsStart);
    sof_d       = run_eff && boundary;
    frame_cnt_d = sof_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
    x_w         = hcnt_q - HActStart;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      running_q   <= 1'b0;
      vs_q        <= 1'b0;
      hs_q        <= 1'b0;
      de_q        <= 1'b0;
      sof_q       <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      running_q   <= running_d;
      vs_q        <= vs_d;
      hs_q        <= hs_d;
      de_q        <= de_d;
      sof_q       <= sof_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign boundary_o  = boundary;
  assign de_next_o   = de_d;
  assign x_o         = 8'(x_w);
  assign y_o         = 8'(vcnt_q);
  assign vs_o        = vs_q;
  assign hs_o        = hs_q;
  assign de_o        = de_q;
  assign sof_o       = sof_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source: timing core plus a registered 4-mode RGB pattern mux.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACT    = 16,
  parameter int unsigned V_ACT    = 16,
  parameter int unsigned H_BP     = 4,
  parameter int unsigned H_FP     = 4,
  parameter int unsigned H_SYNC   = 4,
  parameter int unsigned V_BLANK  = 4,
  parameter int unsigned CHK_LOG2 = 2
) (
  input logic   vga_clk,
  input logic   rst,
  vga_if.master vid
);

  logic        boundary, de_next;
  logic [7:0]  x, y, frame_cnt;
  logic        vs, hs, de, sof;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  xy;
  logic        chk;
  rgb_t        rgb;

  vga_timing #(
    .H_ACT  (H_ACT),
    .V_ACT  (V_ACT),
    .H_BP   (H_BP),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .V_BLANK(V_BLANK)
  ) u_timing (
    .clk_i      (vga_clk),
    .rst_i      (rst),
    .en_i       (vid.en),
    .boundary_o (boundary),
    .de_next_o  (de_next),
    .x_o        (x),
    .y_o        (y),
    .vs_o       (vs),
    .hs_o       (hs),
    .de_o       (de),
    .sof_o      (sof),
    .frame_cnt_o(frame_cnt)
  );

  always_comb begin
    mode_d = boundary ? vid.mode : mode_q;
    xy     = x ^ y;
    chk    = |(xy & (8'd1 << CHK_LOG2));
    case (mode_q)
      PAT_SOLID: rgb = rgb_t'(vid.solid_rgb);
      PAT_RAMP:  rgb = '{r: x, g: y, b: 8'h00};
      PAT_CHK:   rgb = chk ? '1 : '0;
      PAT_ANIM:  rgb = '{r: x + frame_cnt, g: y, b: frame_cnt};
      default:   rgb = '0;
    endcase
    // frame_cnt has already stepped at sof, before any pixel of the new frame
    data_d = de_next ? {8'h00, rgb} : 32'h0;
  end

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      mode_q <= PAT_SOLID;
      data_q <= 32'h0;
    end else begin
      mode_q <= mode_d;
      data_q <= data_d;
    end
  end

  assign vid.vga_vs    = vs;
  assign vid.vga_hs    = hs;
  assign vid.vga_de    = de;
  assign vid.vga_data  = data_q;
  assign vid.frame_cnt = frame_cnt;
  assign vid.sof       = sof;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen at default 16x16 geometry (28x20 total).
module tb_vga_pattern_gen;

  logic clk;
  logic rst;
  vga_if vid ();

  vga_pattern_gen dut (
    .vga_clk(clk),
    .rst    (rst),
    .vid    (vid)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [23:0] solid;
    int          x;
    int          y;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          bad_idle = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // data must be zero outside de, and the top byte is always zero
  always @(negedge clk) begin
    if (!rst && ((!vid.vga_de && vid.vga_data != 32'h0) || vid.vga_data[31:24] != 8'h00))
      bad_idle++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic start(input logic [1:0] m, input logic [23:0] s);
    rst = 1'b1;
    vid.en = 1'b1;
    vid.mode = m;
    vid.solid_rgb = s;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_sof(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (vid.sof) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Advance until the de cycle with frame-relative index target is on the outputs.
  task automatic count_de(input int target, inout int idx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (vid.vga_de) begin
        if (idx == target) begin
          idx++;
          ok = 1'b1;
          return;
        end
        idx++;
      end
    end
  endtask

  // Called with sof on the outputs; returns at the next sof.
  task automatic frame_stats(input logic [23:0] solid, output int period, output int de_n,
                             output int de_line0, output int first_de, output int hs_n,
                             output int vs_n, output int bad_solid, output bit ok);
    period = 0; de_n = 0; de_line0 = 0; first_de = -1; hs_n = 0; vs_n = 0; bad_solid = 0;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (c > 0 && vid.sof) begin
        period = c;
        ok = 1'b1;
        return;
      end
      if (vid.vga_de) begin
        de_n++;
        if (c < 28) de_line0++;
        if (first_de < 0) first_de = c;
        if (vid.vga_data[23:0] != solid) bad_solid++;
      end
      if (vid.vga_hs) hs_n++;
      if (vid.vga_vs) vs_n++;
      @(negedge clk);
    end
  endtask

  initial begin
    bit ok;
    int idx, period, de_n, de_l0, first_de, hs_n, vs_n, bad_s, n_sof;

    vecs[0] = '{2'd1, 24'h0, 5, 3, 32'h00050300};
    vecs[1] = '{2'd1, 24'h0, 15, 15, 32'h000F0F00};
    vecs[2] = '{2'd0, 24'h12AB34, 7, 9, 32'h0012AB34};
    vecs[3] = '{2'd2, 24'h0, 0, 0, 32'h00000000};
    vecs[4] = '{2'd2, 24'h0, 4, 0, 32'h00FFFFFF};
    vecs[5] = '{2'd2, 24'h0, 4, 4, 32'h00000000};
    vecs[6] = '{2'd2, 24'h0, 3, 4, 32'h00FFFFFF};
    vecs[7] = '{2'd2, 24'h0, 12, 0, 32'h00FFFFFF};
    vecs[8] = '{2'd3, 24'h0, 1, 0, 32'h00020001};
    vecs[9] = '{2'd3, 24'h0, 10, 6, 32'h000B0601};

    rst = 1'b0;
    vid.en = 1'b0;
    vid.mode = 2'd0;
    vid.solid_rgb = 24'h0;
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_outputs", {vid.vga_vs, vid.vga_hs, vid.vga_de, vid.sof, vid.frame_cnt,
                            vid.vga_data}, 64'h0);

    // en low: stays idle
    rst = 1'b0;
    n_sof = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (vid.sof || vid.vga_vs || vid.vga_hs) n_sof++;
    end
    check("idle_no_activity", n_sof, 0);

    // Frame timing, ramp mode, two frames
    start(2'd1, 24'h0);
    wait_sof(ok);
    check("b_sof_seen", ok, 1);
    check("b_frame_cnt1", vid.frame_cnt, 8'd1);
    frame_stats(24'h0, period, de_n, de_l0, first_de, hs_n, vs_n, bad_s, ok);
    check("b_frame_end", ok, 1);
    check("b_period", period, 560);
    check("b_de_per_frame", de_n, 256);
    check("b_de_line0", de_l0, 16);
    check("b_first_de_ofs", first_de, 4);
    check("b_hs_per_frame", hs_n, 80);
    check("b_vs_per_frame", vs_n, 448);
    check("b_frame_cnt2", vid.frame_cnt, 8'd2);
    frame_stats(24'h0, period, de_n, de_l0, first_de, hs_n, vs_n, bad_s, ok);
    check("b_period2", period, 560);

    // Solid mode: every de pixel carries solid_rgb
    start(2'd0, 24'h12AB34);
    wait_sof(ok);
    check("s_sof_seen", ok, 1);
    frame_stats(24'h12AB34, period, de_n, de_l0, first_de, hs_n, vs_n, bad_s, ok);
    check("s_de_per_frame", de_n, 256);
    check("s_solid_pixels", bad_s, 0);

    // Table-driven pixel vectors, each from a fresh reset (first frame, frame_cnt=1)
    for (int i = 0; i < 10; i++) begin
      start(vecs[i].mode, vecs[i].solid);
      exp_q.push_back(vecs[i].exp);
      wait_sof(ok);
      idx = 0;
      count_de(vecs[i].y * 16 + vecs[i].x, idx, ok);
      check($sformatf("vec%0d_reached", i), ok, 1);
      check($sformatf("vec%0d_pix", i), vid.vga_data, exp_q.pop_front());
    end

    // Mode change 1->3 on line 8 takes effect only at the next frame
    start(2'd1, 24'h0);
    wait_sof(ok);
    idx = 0;
    count_de(8 * 16, idx, ok);
    vid.mode = 2'd3;
    exp_q.push_back(32'h00020900);
    count_de(9 * 16 + 2, idx, ok);
    check("c_cur_frame_ramp", vid.vga_data, exp_q.pop_front());
    exp_q.push_back(32'h00030002);
    wait_sof(ok);
    check("c_frame_cnt2", vid.frame_cnt, 8'd2);
    idx = 0;
    count_de(1, idx, ok);
    check("c_next_frame_anim", vid.vga_data, exp_q.pop_front());

    // en dropped on line 5: frame completes, then idle
    wait_sof(ok);
    check("d_frame_cnt3", vid.frame_cnt, 8'd3);
    idx = 0;
    count_de(5 * 16, idx, ok);
    vid.en = 1'b0;
    de_n = 0; vs_n = 0; n_sof = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (vid.vga_de) de_n++;
      if (vid.vga_vs) vs_n++;
      if (vid.sof) n_sof++;
    end
    check("d_rest_de", de_n, 175);
    check("d_rest_vs", vs_n, 303);
    check("d_no_sof", n_sof, 0);
    check("d_frame_cnt_hold", vid.frame_cnt, 8'd3);
    vid.en = 1'b1;
    @(negedge clk);
    check("d_restart_sof", vid.sof, 1);
    check("d_restart_cnt", vid.frame_cnt, 8'd4);

    // Async reset mid-line while de is high
    idx = 0;
    count_de(20, idx, ok);
    check("e_de_before_rst", vid.vga_de, 1);
    rst = 1'b1;
    #1;
    check("e_async_zero", {vid.vga_vs, vid.vga_hs, vid.vga_de, vid.sof, vid.frame_cnt,
                           vid.vga_data}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_sof(ok);
    check("e_sof_after_rst", ok, 1);
    check("e_frame_cnt1", vid.frame_cnt, 8'd1);

    check("idle_data_zero", bad_idle, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Synthesizable video source that produces the vga_vs / vga_de / vga_data stream consumed by the frame-logging and skin-detection stages.
- Contains horizontal and vertical timing counters, a frame counter, and a 4-mode RGB test-pattern generator.
- Default geometry is a 16x16 active frame. This matches the P6 16x16 frame dumps used in simulation.
- vga_vs is a frame-valid signal: high across the active lines, low during vertical blanking.

Parameters:
- H_ACT, 16, active pixels per line (1..256)
- V_ACT, 16, active lines per frame (1..256)
- H_BP, 4, blank cycles before active pixels in each line (>=1)
- H_FP, 4, blank cycles after active pixels, before hsync
- H_SYNC, 4, hsync width in cycles
- V_BLANK, 4, blank lines after the active lines (>=1)
- CHK_LOG2, 2, log2 of the checkerboard square size in pixels

Ports:
- vga_clk, in, 1, pixel clock
- rst, in, 1, asynchronous active-high reset
- en, in, 1, run request; sampled only at frame boundary
- mode, in, 2, pattern select; sampled only at frame boundary
- solid_rgb, in, 24, colour used by mode 0
- vga_vs, out, 1, frame valid (high during lines 0..V_ACT-1)
- vga_hs, out, 1, horizontal sync, active high
- vga_de, out, 1, pixel data valid
- vga_data, out, 32, {8'h00, R, G, B}
- frame_cnt, out, 8, number of completed started frames, wraps
- sof, out, 1, one-cycle pulse at the first cycle of each frame

Behaviour:
- Reset (async): hcnt=0, vcnt=0, frame_cnt=0, running=0, mode_q=0. All outputs 0.
- H_TOTAL = H_BP+H_ACT+H_FP+H_SYNC. V_TOTAL = V_ACT+V_BLANK.
- Frame boundary means hcnt=0 and vcnt=0.
- States:
  - IDLE (running=0): counters held at 0; outputs 0.
  - RUN (running=1): counters advance.
- At each frame boundary:
  - running <= en and mode_q <= mode.
  - If en=1, the frame starts.
  - en or mode changes mid-frame have no effect until the next boundary.
- RUN counting:
  - hcnt increments each cycle and wraps H_TOTAL-1 -> 0.
  - On that wrap, vcnt increments and wraps V_TOTAL-1 -> 0.
- All outputs are registered: the outputs in cycle n are a function of (hcnt, vcnt) in cycle n-1. Latency is exactly 1 cycle.
- vga_vs = running and vcnt < V_ACT.
- vga_de = running, vcnt < V_ACT, and H_BP <= hcnt < H_BP+H_ACT.
- vga_hs = running and hcnt >= H_BP+H_ACT+H_FP.
- Because H_BP >= 1, the vga_vs rising edge always precedes the first de by at least one cycle. No pixel coincides with the vs edge.
- sof = 1 for exactly one cycle, coincident with the vga_vs rising edge.
- frame_cnt increments (mod 256) on the same cycle as sof and is visible from that cycle onward.
- Pixel coordinates: x = hcnt-H_BP and y = vcnt, each 8 bits wide.
- Patterns, selected by mode_q:
  - 0: RGB = solid_rgb
  - 1: R=x, G=y, B=0
  - 2: RGB = FFFFFF if x[CHK_LOG2] xor y[CHK_LOG2], else 000000
  - 3: R = x+frame_cnt (mod 256), G = y, B = frame_cnt
- When vga_de=0, vga_data = 0. vga_data[31:24] is always 0.
- en deasserted mid-frame: the current frame completes, then the block enters IDLE at the boundary.
- Reset mid-frame: outputs drop to 0 immediately (async). The next frame starts at hcnt=0 after release if en=1.

Decomposition:
- Package vga_pkg holds:
  - pattern mode localparams (PAT_SOLID=0, PAT_RAMP=1, PAT_CHK=2, PAT_ANIM=3)
  - the rgb_t typedef (24-bit struct)
  - a function computing H_TOTAL and V_TOTAL
- Sub-module vga_timing holds the counters, running flag, and vs/hs/de/sof.
- The pattern mux lives in the top level.

Test Plan:
- Default params, en=1, mode=1, 2 frames:
  - vs period is 560 cycles; 256 de cycles per frame, 16 per line.
  - First de is 4 cycles after the vs rise.
  - Pixel (x=5, y=3) has data 32'h00050300.
  - frame_cnt goes 1, then 2.
- mode=0, solid_rgb=24'h12AB34: every de cycle has data 32'h0012AB34; every non-de cycle has data 0.
- mode=2, CHK_LOG2=2: (x=0,y=0) is 000000; (x=4,y=0) is FFFFFF; (x=4,y=4) is 000000.
- Mode change 1->3 at vcnt=8:
  - The current frame stays ramp.
  - The next frame (frame_cnt=2) has (x=1,y=0) data 32'h00030002.
- en dropped at vcnt=5:
  - The frame completes; vs stays low afterwards and sof does not recur.
  - Re-asserting en starts a frame within 1 cycle with frame_cnt+1.
- rst asserted mid-line with de=1: all outputs are 0 in the same cycle (async). After release, the next vs rise has frame_cnt=1.
